// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//   UART transmit controller. Pops bytes from a first-word-fall-through FIFO
//   and serialises them one bit per CLK: start bit, D_Width data bits LSB
//   first, optional parity bit, STOP_BITS stop bits. Frames run back to back
//   with no idle gap while the FIFO holds data.
//
//   Build option: define TX_PARITY_EN to compile in the parity bit and the
//   PARITY state. Without it PAR_EN/PAR_TYP are accepted but ignored.
//
// Parameters
//   D_Width    data byte width
//   STOP_BITS  stop-bit cycles, 1 or 2
//
// Ports
//   CLK         in   baud-rate clock, one serial bit per cycle
//   RST         in   asynchronous active-high reset
//   FIFO_EMPTY  in   FIFO read-side empty flag (already in CLK domain)
//   RD_DATA     in   FIFO head word, valid while FIFO_EMPTY=0
//   PAR_EN      in   parity enable (sampled when a byte is popped)
//   PAR_TYP     in   parity type, 0=even 1=odd (sampled when popped)
//   RD_INC      out  FIFO pop strobe, one cycle per byte
//   TX_OUT      out  registered serial line, idle high
//   Busy        out  high from start bit through last stop bit
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int D_Width   = 8,
    parameter int STOP_BITS = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               FIFO_EMPTY,
    input  logic [D_Width-1:0] RD_DATA,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    output logic               RD_INC,
    output logic               TX_OUT,
    output logic               Busy
);

    localparam int CNT_W = (D_Width > 1) ? $clog2(D_Width) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(D_Width - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [D_Width-1:0] r_data;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               r_stop_cnt;
    logic               r_tx;
    logic               w_tx_nxt;
    logic               w_pop;
    logic               w_last_stop;

    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    assign w_last_stop = (r_state == STOP) && ((STOP_BITS == 1) || r_stop_cnt);

`ifdef TX_PARITY_EN
    logic r_par_en;
    logic r_par_typ;
    logic w_par_bit;

    // Parity is taken from the latched byte so FIFO movement cannot alter it.
    assign w_par_bit = (^r_data) ^ r_par_typ;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
        end else if (w_pop) begin
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
        end
    end
`else
    logic w_unused_par;
    assign w_unused_par = PAR_EN ^ PAR_TYP;
`endif

    // Next-state logic also produces the line value for the next cycle, so
    // TX_OUT comes straight from a flop and never glitches.
    always_comb begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!FIFO_EMPTY) begin
                    w_pop       = 1'b1;
                    w_state_nxt = START;
                    w_tx_nxt    = 1'b0;
                end
            end
            START: begin
                w_state_nxt = DATA;
                w_tx_nxt    = r_data[0];
            end
            DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = STOP;
`ifdef TX_PARITY_EN
                    if (r_par_en) begin
                        w_state_nxt = PARITY;
                        w_tx_nxt    = w_par_bit;
                    end
`endif
                end else begin
                    w_state_nxt = DATA;
                    w_tx_nxt    = r_data[w_cnt_inc];
                end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
                w_state_nxt = STOP;
            end
`endif
            STOP: begin
                if (w_last_stop) begin
                    // Back-to-back: pop the next byte in the last stop cycle.
                    if (!FIFO_EMPTY) begin
                        w_pop       = 1'b1;
                        w_state_nxt = START;
                        w_tx_nxt    = 1'b0;
                    end
                end else begin
                    w_state_nxt = STOP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= IDLE;
            r_tx       <= 1'b1;
            r_data     <= '0;
            r_cnt      <= '0;
            r_stop_cnt <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx       <= w_tx_nxt;
            r_stop_cnt <= (r_state == STOP) && (w_state_nxt == STOP);
            if (w_pop) begin
                r_data <= RD_DATA;
                r_cnt  <= '0;
            end else if (r_state == DATA) begin
                r_cnt  <= w_cnt_inc;
            end
        end
    end

    // Gate the pop with reset so a waiting FIFO is never drained during reset.
    assign RD_INC = w_pop & ~RST;
    assign TX_OUT = r_tx;
    assign Busy   = (r_state == START) || (r_state == DATA) ||
                    (r_state == STOP)
`ifdef TX_PARITY_EN
                    || (r_state == PARITY)
`endif
                    ;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: a FIFO model feeds the DUT and queues
// each popped byte's expected frame; a line monitor decodes TX_OUT and
// compares bit by bit.
module tb_uart_tx_ctrl;

    localparam int D  = 8;
    localparam int SB = 1;

    logic         CLK        = 1'b0;
    logic         RST        = 1'b1;
    logic         FIFO_EMPTY = 1'b1;
    logic [D-1:0] RD_DATA    = '0;
    logic         PAR_EN     = 1'b0;
    logic         PAR_TYP    = 1'b0;
    logic         RD_INC;
    logic         TX_OUT;
    logic         Busy;

    uart_tx_ctrl #(.D_Width(D), .STOP_BITS(SB)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .FIFO_EMPTY (FIFO_EMPTY),
        .RD_DATA    (RD_DATA),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .RD_INC     (RD_INC),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [D-1:0] d;
        logic         pe;
        logic         pt;
    } frm_t;

    logic [D-1:0] fifo_q[$];
    frm_t         exp_q[$];
    int           checks   = 0;
    int           failures = 0;
    int           pushes   = 0;
    int           pops     = 0;
    bit           in_frame = 0;
    frm_t         cur;
    int           idx;
    frm_t         f_pop;
    bit           do_pop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit par_on(input frm_t f);
`ifdef TX_PARITY_EN
        return f.pe;
`else
        return 1'b0 & f.pe;
`endif
    endfunction

    // Bits after the start bit: data LSB first, optional parity, stop bits.
    function automatic int frame_len(input frm_t f);
        return D + (par_on(f) ? 1 : 0) + SB;
    endfunction

    function automatic logic exp_bit(input frm_t f, input int i);
        if (i < D) return f.d[i];
        if (par_on(f) && i == D) return (^f.d) ^ f.pt;
        return 1'b1;
    endfunction

    task automatic drive_fifo();
        FIFO_EMPTY = (fifo_q.size() == 0);
        if (fifo_q.size() != 0) RD_DATA = fifo_q[0];
        else                    RD_DATA = '0;
    endtask

    task automatic push(input logic [D-1:0] b);
        fifo_q.push_back(b);
        pushes++;
        drive_fifo();
    endtask

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic drain();
        int n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || in_frame) && n < 2000) begin
            cyc();
            n++;
        end
        chk("drain_done", (n < 2000), 1);
        repeat (2) cyc();
    endtask

    // FIFO model: a pop seen during the cycle is applied just after the edge,
    // and the expected frame is queued at the same moment.
    initial forever begin
        @(negedge CLK);
        do_pop = (RD_INC === 1'b1) && (fifo_q.size() != 0);
        if (do_pop) begin
            f_pop.d  = fifo_q[0];
            f_pop.pe = PAR_EN;
            f_pop.pt = PAR_TYP;
        end
        @(posedge CLK);
        #1;
        if (do_pop) begin
            void'(fifo_q.pop_front());
            exp_q.push_back(f_pop);
            pops++;
            drive_fifo();
        end
    end

    // Line monitor.
    initial forever begin
        @(negedge CLK);
        if (RST) begin
            in_frame = 0;
            exp_q.delete();
            chk("rst_tx", TX_OUT, 1);
            chk("rst_busy", Busy, 0);
            chk("rst_rdinc", RD_INC, 0);
        end else begin
            chk("rdinc_when_empty", RD_INC & FIFO_EMPTY, 0);
            if (in_frame) begin
                chk("frame_bit", TX_OUT, exp_bit(cur, idx));
                chk("frame_busy", Busy, 1);
                if (idx != frame_len(cur) - 1) chk("rdinc_mid_frame", RD_INC, 0);
                idx++;
                if (idx == frame_len(cur)) in_frame = 0;
            end else if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                chk("start_bit", TX_OUT, 0);
                chk("start_busy", Busy, 1);
                chk("rdinc_start", RD_INC, 0);
                idx      = 0;
                in_frame = 1;
            end else begin
                chk("idle_tx", TX_OUT, 1);
                chk("idle_busy", Busy, 0);
            end
        end
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge CLK);
        #3 RST = 1'b0;
        repeat (2) cyc();

        // Even parity 0xA5, odd parity 0x07.
        PAR_EN = 1'b1; PAR_TYP = 1'b0;
        push(8'hA5);
        drain();
        PAR_TYP = 1'b1;
        push(8'h07);
        drain();

        // Back-to-back pair without parity.
        PAR_EN = 1'b0;
        push(8'h55);
        push(8'h0F);
        drain();

        // Long idle with empty FIFO.
        repeat (50) cyc();

        // Reset during data bit 3 of 0xFF.
        push(8'hFF);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!Busy && n < 20);
        chk("busy_rise", Busy, 1);
        repeat (4) @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        chk("rst_async_tx", TX_OUT, 1);
        chk("rst_async_busy", Busy, 0);
        chk("rst_async_rdinc", RD_INC, 0);
        repeat (2) @(posedge CLK);
        #3 RST = 1'b0;
        repeat (20) cyc();

        // Parity requested on 0x81.
        PAR_EN = 1'b1; PAR_TYP = 1'b0;
        push(8'h81);
        drain();

        // Random traffic with parity controls toggling mid-frame.
        for (int i = 0; i < 400; i++) begin
            cyc();
            if ($urandom_range(0, 3) == 0 && fifo_q.size() < 4) push(8'($urandom));
            if ($urandom_range(0, 7) == 0) PAR_EN  = ~PAR_EN;
            if ($urandom_range(0, 7) == 0) PAR_TYP = ~PAR_TYP;
        end
        drain();

        chk("pop_count", pops, pushes);
        chk("exp_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
